// File: rtl/mul_array_pkg.sv
// Shared constants for the 32-lane 26x8 multiplier array and its consumer-side drain.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default array geometry and pipeline depth, default beat count, lane bit-offset helper.
package mul_array_pkg;

  // Defaults must match the multiplier array instance parameters.
  localparam int DEF_NUM_MULTIPLIERS = 32;
  localparam int DEF_PROD_W          = 34;  // 26-bit x 8-bit product
  localparam int DEF_MUL_LATENCY     = 4;
  localparam int DEF_LANES_PER_BEAT  = 4;
  localparam int DEF_BEATS           = DEF_NUM_MULTIPLIERS / DEF_LANES_PER_BEAT;

  // Bit offset of a lane inside a packed product vector.
  function automatic int lane_lsb(input int lane, input int prod_w);
    return lane * prod_w;
  endfunction

endpackage

// File: rtl/mul_prod_fifo.sv
// Synchronous FIFO of full product vectors with first-word-fall-through head.
// Latency: a push at edge k is visible on head/count from cycle k+1 (no bypass).
// Backpressure: none; the writer is credit-limited, a push into a full FIFO is dropped.
// Ports: clk, rst_n (async low); push/wdata write port; pop removes head;
//        head = oldest entry, count = occupancy, empty = (count == 0).
module mul_prod_fifo #(
  parameter int WIDTH = 1088,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Credit upstream should make this impossible; hardware silently drops it.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/mul_array_drain.sv
// Consumer end of the multiplier array: tracks issues through the fixed pipeline, buffers product vectors, streams beats.
// Latency: issue at edge k -> capture at edge k+MUL_LATENCY -> first beat on m_data_o in cycle k+MUL_LATENCY+1.
// Backpressure: m_ready_i stalls beats (outputs hold); issue_ready_o is a registered credit so the FIFO never overruns.
// Ports: clk_i, rst_ni (async low); issue_valid_i/issue_ready_o issue handshake; mul_p_i array product bus;
//        m_valid_o/m_ready_i/m_data_o/m_beat_o/m_last_o beat stream; overflow_o sticky rejected-issue flag.
module mul_array_drain
  import mul_array_pkg::*;
#(
  parameter int NUM_MULTIPLIERS = DEF_NUM_MULTIPLIERS,
  parameter int PROD_W          = DEF_PROD_W,
  parameter int MUL_LATENCY     = DEF_MUL_LATENCY,
  parameter int DEPTH           = 4,
  parameter int LANES_PER_BEAT  = DEF_LANES_PER_BEAT,
  localparam int BEATS  = NUM_MULTIPLIERS / LANES_PER_BEAT,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               issue_valid_i,
  output logic                               issue_ready_o,
  input  logic [NUM_MULTIPLIERS*PROD_W-1:0]  mul_p_i,
  output logic                               m_valid_o,
  input  logic                               m_ready_i,
  output logic [LANES_PER_BEAT*PROD_W-1:0]   m_data_o,
  output logic [BEAT_W-1:0]                  m_beat_o,
  output logic                               m_last_o,
  output logic                               overflow_o
);

  localparam int VEC_W   = NUM_MULTIPLIERS * PROD_W;
  localparam int BEAT_DW = LANES_PER_BEAT * PROD_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int INF_W   = $clog2(MUL_LATENCY + 1);

  logic [MUL_LATENCY-1:0] tap_q;
  logic [MUL_LATENCY-1:0] tap_d;
  logic [INF_W-1:0]       inflight_q;
  logic [BEAT_W-1:0]      beat_q;
  logic                   overflow_q;

  logic                   issue_ok;
  logic                   push;
  logic                   pop;
  logic                   hs;
  logic                   last_beat;
  logic [VEC_W-1:0]       head;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;

  // Every in-flight operand set already owns a FIFO slot, so a full FIFO
  // plus pipeline blocks further issue.
  assign issue_ready_o = (int'(fifo_count) + int'(inflight_q)) < DEPTH;
  assign issue_ok      = issue_valid_i && issue_ready_o;
  assign push          = tap_q[MUL_LATENCY-1];

  // Delay line: bit i set means an accepted issue is i+1 edges old.
  always_comb begin
    tap_d    = '0;
    tap_d[0] = issue_ok;
    for (int i = 1; i < MUL_LATENCY; i++) tap_d[i] = tap_q[i-1];
  end

  assign m_valid_o = !fifo_empty;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign hs        = m_valid_o && m_ready_i;
  assign pop       = hs && last_beat;
  assign m_beat_o  = beat_q;
  assign m_last_o  = m_valid_o && last_beat;
  assign m_data_o  = m_valid_o
                     ? head[lane_lsb(int'(beat_q) * LANES_PER_BEAT, PROD_W) +: BEAT_DW]
                     : '0;
  assign overflow_o = overflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tap_q      <= '0;
      inflight_q <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      tap_q      <= tap_d;
      inflight_q <= inflight_q + INF_W'(issue_ok) - INF_W'(push);
      if (hs) beat_q <= last_beat ? '0 : beat_q + 1'b1;
      if (issue_valid_i && !issue_ready_o) overflow_q <= 1'b1;
    end
  end

  mul_prod_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata (mul_p_i),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule
